// File: rtl/xif_coproc_mux_if.sv
// Bundle of core-side and coprocessor-side issue/commit/result signals for
// the coprocessor multiplexer. The mux itself uses the slave view; whatever
// drives the core requests and models the coprocessors uses the master view.
interface xif_coproc_mux_if #(
    parameter int NUM_CP    = 2,
    parameter int ID_W      = 4,
    parameter int PAYLOAD_W = 96,
    parameter int RES_W     = 38
);
    // core-side issue
    logic                    c_issue_valid_i;
    logic                    c_issue_ready_o;
    logic [ID_W-1:0]         c_issue_id_i;
    logic [PAYLOAD_W-1:0]    c_issue_payload_i;
    logic                    c_issue_accept_o;
    // core-side commit
    logic                    c_commit_valid_i;
    logic [ID_W-1:0]         c_commit_id_i;
    logic                    c_commit_kill_i;
    // core-side result
    logic                    c_result_valid_o;
    logic                    c_result_ready_i;
    logic [ID_W-1:0]         c_result_id_o;
    logic [RES_W-1:0]        c_result_data_o;
    // coprocessor-side issue
    logic [NUM_CP-1:0]       cp_issue_valid_o;
    logic [NUM_CP-1:0]       cp_issue_ready_i;
    logic [NUM_CP-1:0]       cp_issue_accept_i;
    logic [ID_W-1:0]         cp_issue_id_o;
    logic [PAYLOAD_W-1:0]    cp_issue_payload_o;
    // coprocessor-side commit
    logic [NUM_CP-1:0]       cp_commit_valid_o;
    logic [ID_W-1:0]         cp_commit_id_o;
    logic                    cp_commit_kill_o;
    // coprocessor-side result, coprocessor k at slice k
    logic [NUM_CP-1:0]       cp_result_valid_i;
    logic [NUM_CP-1:0]       cp_result_ready_o;
    logic [NUM_CP*ID_W-1:0]  cp_result_id_i;
    logic [NUM_CP*RES_W-1:0] cp_result_data_i;

    modport slave (
        input  c_issue_valid_i, c_issue_id_i, c_issue_payload_i,
        input  c_commit_valid_i, c_commit_id_i, c_commit_kill_i,
        input  c_result_ready_i,
        input  cp_issue_ready_i, cp_issue_accept_i,
        input  cp_result_valid_i, cp_result_id_i, cp_result_data_i,
        output c_issue_ready_o, c_issue_accept_o,
        output c_result_valid_o, c_result_id_o, c_result_data_o,
        output cp_issue_valid_o, cp_issue_id_o, cp_issue_payload_o,
        output cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o,
        output cp_result_ready_o
    );

    modport master (
        output c_issue_valid_i, c_issue_id_i, c_issue_payload_i,
        output c_commit_valid_i, c_commit_id_i, c_commit_kill_i,
        output c_result_ready_i,
        output cp_issue_ready_i, cp_issue_accept_i,
        output cp_result_valid_i, cp_result_id_i, cp_result_data_i,
        input  c_issue_ready_o, c_issue_accept_o,
        input  c_result_valid_o, c_result_id_o, c_result_data_o,
        input  cp_issue_valid_o, cp_issue_id_o, cp_issue_payload_o,
        input  cp_commit_valid_o, cp_commit_id_o, cp_commit_kill_o,
        input  cp_result_ready_o
    );
endinterface

// File: rtl/xif_coproc_mux.sv
// Fans one core-side extension interface out to NUM_CP coprocessors.
// An owner table indexed by instruction ID remembers which coprocessor took
// each instruction so commits go to the owner only; per-coprocessor
// outstanding counters throttle offers; results are merged round-robin into
// a single registered result slot towards the core.
module xif_coproc_mux #(
    parameter int NUM_CP    = 2,
    parameter int ID_W      = 4,
    parameter int PAYLOAD_W = 96,
    parameter int RES_W     = 38,
    parameter int MAX_OUTST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    xif_coproc_mux_if.slave       bus,
    output logic                  busy_o
);
    localparam int DEPTH = 2 ** ID_W;
    localparam int CP_W  = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
    localparam int CNT_W = 4;

    logic [DEPTH-1:0] tbl_valid_q, tbl_valid_d;
    logic [CP_W-1:0]  tbl_owner_q [DEPTH];
    logic [CP_W-1:0]  tbl_owner_d [DEPTH];
    logic [CNT_W-1:0] outst_q [NUM_CP];
    logic [CNT_W-1:0] outst_d [NUM_CP];
    logic [CP_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [RES_W-1:0] res_data_q, res_data_d;

    logic [NUM_CP-1:0] masked;
    logic [NUM_CP-1:0] acc_vec;
    logic              id_busy;
    logic              offer;
    logic              issue_fire;
    logic [CP_W-1:0]   issue_owner;
    logic              commit_hit;
    logic              kill_fire;
    logic [CP_W-1:0]   commit_owner;
    logic              capture_en;
    logic              win_found;
    logic [CP_W-1:0]   winner;
    logic [CP_W-1:0]   scan_idx;
    logic              res_grant;
    logic [ID_W-1:0]   win_id;
    logic [RES_W-1:0]  win_data;
    logic              res_clear;

    assign id_busy    = tbl_valid_q[bus.c_issue_id_i];
    assign offer      = bus.c_issue_valid_i & ~id_busy;
    assign commit_hit = bus.c_commit_valid_i & tbl_valid_q[bus.c_commit_id_i];
    assign commit_owner = tbl_owner_q[bus.c_commit_id_i];
    assign kill_fire  = commit_hit & bus.c_commit_kill_i;

    assign bus.cp_issue_id_o      = bus.c_issue_id_i;
    assign bus.cp_issue_payload_o = bus.c_issue_payload_i;
    assign bus.cp_commit_id_o     = bus.c_commit_id_i;
    assign bus.cp_commit_kill_o   = bus.c_commit_kill_i;
    assign bus.c_result_valid_o   = res_valid_q;
    assign bus.c_result_id_o      = res_id_q;
    assign bus.c_result_data_o    = res_data_q;
    assign busy_o                 = (|tbl_valid_q) | res_valid_q;

    // Issue side: mask full coprocessors, wait for all unmasked ones, pick the lowest acceptor
    always_comb begin
        masked = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            masked[k] = (outst_q[k] == CNT_W'(MAX_OUTST));
        end
        acc_vec              = bus.cp_issue_ready_i & bus.cp_issue_accept_i & ~masked;
        bus.cp_issue_valid_o = {NUM_CP{offer}} & ~masked;
        bus.c_issue_ready_o  = offer & (&(bus.cp_issue_ready_i | masked));
        bus.c_issue_accept_o = bus.c_issue_ready_o & (|acc_vec);
        issue_fire           = bus.c_issue_accept_o;
        issue_owner          = '0;
        for (int k = NUM_CP - 1; k >= 0; k--) begin
            if (acc_vec[k]) issue_owner = CP_W'(k);
        end
    end

    // Commit side: only a known ID reaches its owning coprocessor
    always_comb begin
        bus.cp_commit_valid_o = '0;
        if (commit_hit) bus.cp_commit_valid_o[commit_owner] = 1'b1;
    end

    // Result side: round-robin search starting at the pointer
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            scan_idx = CP_W'((int'(rr_ptr_q) + i) % NUM_CP);
            if (!win_found && bus.cp_result_valid_i[scan_idx]) begin
                win_found = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    assign capture_en = ~res_valid_q | bus.c_result_ready_i;
    assign res_grant  = win_found & capture_en;
    assign win_id     = bus.cp_result_id_i[int'(winner)*ID_W +: ID_W];
    assign win_data   = bus.cp_result_data_i[int'(winner)*RES_W +: RES_W];
    // a kill of the same entry in the same cycle already frees it, so do not count it twice
    assign res_clear  = res_grant & tbl_valid_q[win_id] & (tbl_owner_q[win_id] == winner)
                      & ~(kill_fire & (bus.c_commit_id_i == win_id));

    // Grant the winning coprocessor its ready only when the slot can take the result
    always_comb begin
        bus.cp_result_ready_o = '0;
        if (res_grant) bus.cp_result_ready_o[winner] = 1'b1;
    end

    // Next-state for the owner table, counters, round-robin pointer and result slot
    always_comb begin
        tbl_valid_d = tbl_valid_q;
        tbl_owner_d = tbl_owner_q;
        if (issue_fire) begin
            tbl_valid_d[bus.c_issue_id_i] = 1'b1;
            tbl_owner_d[bus.c_issue_id_i] = issue_owner;
        end
        if (kill_fire) tbl_valid_d[bus.c_commit_id_i] = 1'b0;
        if (res_clear) tbl_valid_d[win_id] = 1'b0;
        for (int k = 0; k < NUM_CP; k++) begin
            outst_d[k] = outst_q[k]
                       + CNT_W'(issue_fire && (issue_owner == CP_W'(k)))
                       - CNT_W'(kill_fire && (commit_owner == CP_W'(k)))
                       - CNT_W'(res_clear && (winner == CP_W'(k)));
        end
        rr_ptr_d    = rr_ptr_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        if (res_grant) begin
            rr_ptr_d    = (winner == CP_W'(NUM_CP - 1)) ? '0 : winner + 1'b1;
            res_valid_d = 1'b1;
            res_id_d    = win_id;
            res_data_d  = win_data;
        end else if (bus.c_result_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset that drops all in-flight bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tbl_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) tbl_owner_q[i] <= '0;
            for (int k = 0; k < NUM_CP; k++) outst_q[k] <= '0;
            rr_ptr_q    <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            tbl_valid_q <= tbl_valid_d;
            tbl_owner_q <= tbl_owner_d;
            outst_q     <= outst_d;
            rr_ptr_q    <= rr_ptr_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end
endmodule

// File: tb/tb_xif_coproc_mux.sv
// Self-checking bench for xif_coproc_mux: directed scenarios plus a random
// phase compared against a bookkeeping model of owners, counts and results.
module tb_xif_coproc_mux;
    localparam int NUM_CP = 2, ID_W = 4, PAYLOAD_W = 96, RES_W = 38, MAX_OUTST = 4;
    localparam int DEPTH = 16;

    logic clk_i = 1'b0;
    logic rst_i;
    logic busy_o;
    int errors = 0;
    int checks = 0;

    xif_coproc_mux_if #(.NUM_CP(NUM_CP), .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W), .RES_W(RES_W)) bus();

    xif_coproc_mux #(.NUM_CP(NUM_CP), .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W), .RES_W(RES_W),
                     .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus), .busy_o(busy_o));

    always #5 clk_i = ~clk_i;

    // reference model: who owns each ID, how many each coprocessor holds, result slot
    bit               m_valid [DEPTH];
    int               m_owner [DEPTH];
    int               m_outst [NUM_CP];
    int               m_rr = 0;
    bit               m_full = 0;
    logic [ID_W-1:0]  m_res_id = '0;
    logic [RES_W-1:0] m_res_data = '0;
    logic [NUM_CP-1:0] e_cp_issue_valid, e_commit_valid, e_res_ready;
    logic             e_issue_ready, e_issue_accept;
    int               e_owner, e_winner;

    task automatic clear_inputs();
        bus.c_issue_valid_i   = 1'b0;
        bus.c_issue_id_i      = '0;
        bus.c_issue_payload_i = '0;
        bus.c_commit_valid_i  = 1'b0;
        bus.c_commit_id_i     = '0;
        bus.c_commit_kill_i   = 1'b0;
        bus.c_result_ready_i  = 1'b0;
        bus.cp_issue_ready_i  = '0;
        bus.cp_issue_accept_i = '0;
        bus.cp_result_valid_i = '0;
        bus.cp_result_id_i    = '0;
        bus.cp_result_data_i  = '0;
    endtask

    task automatic model_eval();
        bit msk, all_ok;
        int j;
        e_cp_issue_valid = '0;
        all_ok = 1'b1;
        e_owner = -1;
        for (int k = 0; k < NUM_CP; k++) begin
            msk = (m_outst[k] >= MAX_OUTST);
            if (bus.c_issue_valid_i && !m_valid[bus.c_issue_id_i] && !msk) e_cp_issue_valid[k] = 1'b1;
            if (!msk && !bus.cp_issue_ready_i[k]) all_ok = 1'b0;
            if (!msk && bus.cp_issue_ready_i[k] && bus.cp_issue_accept_i[k] && e_owner < 0) e_owner = k;
        end
        e_issue_ready  = bus.c_issue_valid_i && !m_valid[bus.c_issue_id_i] && all_ok;
        e_issue_accept = e_issue_ready && (e_owner >= 0);
        e_commit_valid = '0;
        if (bus.c_commit_valid_i && m_valid[bus.c_commit_id_i]) e_commit_valid[m_owner[bus.c_commit_id_i]] = 1'b1;
        e_winner = -1;
        for (int i = 0; i < NUM_CP; i++) begin
            j = (m_rr + i) % NUM_CP;
            if (e_winner < 0 && bus.cp_result_valid_i[j]) e_winner = j;
        end
        e_res_ready = '0;
        if (e_winner >= 0 && (!m_full || bus.c_result_ready_i)) e_res_ready[e_winner] = 1'b1;
    endtask

    task automatic model_update();
        int cid, rid, w, kown, iid;
        bit kill_hit, res_hit;
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_owner[i] = 0; end
            for (int k = 0; k < NUM_CP; k++) m_outst[k] = 0;
            m_rr = 0;
            m_full = 0;
            return;
        end
        cid = int'(bus.c_commit_id_i);
        kill_hit = bus.c_commit_valid_i && bus.c_commit_kill_i && m_valid[cid];
        kown = m_owner[cid];
        w = e_winner;
        rid = 0;
        res_hit = 0;
        if (e_res_ready != '0) begin
            rid = int'(bus.cp_result_id_i[w*ID_W +: ID_W]);
            res_hit = m_valid[rid] && (m_owner[rid] == w) && !(kill_hit && cid == rid);
        end
        if (e_issue_accept) begin
            iid = int'(bus.c_issue_id_i);
            m_valid[iid] = 1;
            m_owner[iid] = e_owner;
            m_outst[e_owner]++;
        end
        if (kill_hit) begin m_valid[cid] = 0; m_outst[kown]--; end
        if (res_hit) begin m_valid[rid] = 0; m_outst[w]--; end
        if (e_res_ready != '0) begin
            m_full = 1;
            m_res_id = bus.cp_result_id_i[w*ID_W +: ID_W];
            m_res_data = bus.cp_result_data_i[w*RES_W +: RES_W];
            m_rr = (w + 1) % NUM_CP;
        end else if (bus.c_result_ready_i) begin
            m_full = 0;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic do_issue(input int id, input logic [1:0] acc);
        clear_inputs();
        bus.c_issue_valid_i = 1'b1;
        bus.c_issue_id_i = ID_W'(id);
        bus.cp_issue_ready_i = 2'b11;
        bus.cp_issue_accept_i = acc;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        checks++; if (bus.c_result_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b want 0", bus.c_result_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (bus.c_issue_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_issue_ready: got %b want 0", bus.c_issue_ready_o); end
        checks++; if (bus.cp_result_ready_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_cp_res_ready: got %b want 00", bus.cp_result_ready_o); end
        checks++; if (bus.cp_commit_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_commit: got %b want 00", bus.cp_commit_valid_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_issue_route();
        logic [PAYLOAD_W-1:0] pl;
        logic [RES_W-1:0] d;
        apply_reset();
        pl = {$urandom, $urandom, $urandom};
        d = RES_W'({$urandom, $urandom});
        clear_inputs();
        bus.c_issue_valid_i = 1'b1; bus.c_issue_id_i = 4'd3; bus.c_issue_payload_i = pl;
        bus.cp_issue_ready_i = 2'b11; bus.cp_issue_accept_i = 2'b10;
        #1;
        checks++; if (bus.cp_issue_valid_o !== 2'b11) begin errors++; $display("[TB] FAIL route_offer: got %b want 11", bus.cp_issue_valid_o); end
        checks++; if (bus.c_issue_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL route_ready: got %b want 1", bus.c_issue_ready_o); end
        checks++; if (bus.c_issue_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL route_accept: got %b want 1", bus.c_issue_accept_o); end
        checks++; if (bus.cp_issue_payload_o !== pl) begin errors++; $display("[TB] FAIL route_payload: got %h want %h", bus.cp_issue_payload_o, pl); end
        tick();
        clear_inputs();
        bus.c_commit_valid_i = 1'b1; bus.c_commit_id_i = 4'd3;
        #1;
        checks++; if (bus.cp_commit_valid_o !== 2'b10) begin errors++; $display("[TB] FAIL commit_owner: got %b want 10", bus.cp_commit_valid_o); end
        tick();
        clear_inputs();
        bus.c_commit_valid_i = 1'b1; bus.c_commit_id_i = 4'd9;
        #1;
        checks++; if (bus.cp_commit_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL commit_unknown: got %b want 00", bus.cp_commit_valid_o); end
        tick();
        clear_inputs();
        bus.cp_result_valid_i = 2'b10;
        bus.cp_result_id_i[ID_W +: ID_W] = 4'd3;
        bus.cp_result_data_i[RES_W +: RES_W] = d;
        #1;
        checks++; if (bus.cp_result_ready_o !== 2'b10) begin errors++; $display("[TB] FAIL result_grant: got %b want 10", bus.cp_result_ready_o); end
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.c_result_valid_o !== 1'b1 || bus.c_result_id_o !== 4'd3) begin errors++; $display("[TB] FAIL result_out: got v=%b id=%0d want v=1 id=3", bus.c_result_valid_o, bus.c_result_id_o); end
        checks++; if (bus.c_result_data_o !== d) begin errors++; $display("[TB] FAIL result_data: got %h want %h", bus.c_result_data_o, d); end
        tick();
        checks++; if (bus.c_result_valid_o !== 1'b1 || bus.c_result_data_o !== d) begin errors++; $display("[TB] FAIL result_hold: got v=%b data=%h want v=1 data=%h", bus.c_result_valid_o, bus.c_result_data_o, d); end
        bus.c_result_ready_i = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.c_result_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL result_drain: got v=%b busy=%b want 0 0", bus.c_result_valid_o, busy_o); end
    endtask

    task automatic test_max_outst();
        apply_reset();
        for (int i = 0; i < MAX_OUTST; i++) do_issue(4 + i, 2'b01);
        clear_inputs();
        bus.c_issue_valid_i = 1'b1; bus.c_issue_id_i = 4'd8;
        bus.cp_issue_ready_i = 2'b11; bus.cp_issue_accept_i = 2'b01;
        #1;
        checks++; if (bus.cp_issue_valid_o !== 2'b10) begin errors++; $display("[TB] FAIL full_offer: got %b want 10", bus.cp_issue_valid_o); end
        checks++; if (bus.c_issue_ready_o !== 1'b1 || bus.c_issue_accept_o !== 1'b0) begin errors++; $display("[TB] FAIL full_handshake: got r=%b a=%b want r=1 a=0", bus.c_issue_ready_o, bus.c_issue_accept_o); end
        tick();
        clear_inputs();
        bus.cp_result_valid_i = 2'b01;
        bus.cp_result_id_i[0 +: ID_W] = 4'd4;
        bus.c_result_ready_i = 1'b1;
        #1;
        checks++; if (bus.cp_result_ready_o !== 2'b01) begin errors++; $display("[TB] FAIL full_result_grant: got %b want 01", bus.cp_result_ready_o); end
        tick();
        clear_inputs();
        bus.c_issue_valid_i = 1'b1; bus.c_issue_id_i = 4'd9;
        bus.cp_issue_ready_i = 2'b11; bus.cp_issue_accept_i = 2'b01;
        #1;
        checks++; if (bus.cp_issue_valid_o !== 2'b11 || bus.c_issue_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL unmask_offer: got v=%b a=%b want 11 1", bus.cp_issue_valid_o, bus.c_issue_accept_o); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [RES_W-1:0] d0, d1, prev_d;
        logic [ID_W-1:0] prev_id;
        logic [1:0] exp;
        apply_reset();
        prev_d = '0;
        prev_id = '0;
        for (int i = 0; i < 6; i++) begin
            d0 = RES_W'({$urandom, $urandom});
            d1 = RES_W'({$urandom, $urandom});
            clear_inputs();
            bus.cp_result_valid_i = 2'b11;
            bus.cp_result_id_i = {4'd11, 4'd10};
            bus.cp_result_data_i = {d1, d0};
            bus.c_result_ready_i = 1'b1;
            #1;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (bus.cp_result_ready_o !== exp) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", i, bus.cp_result_ready_o, exp); end
            if (i > 0) begin
                checks++; if (bus.c_result_valid_o !== 1'b1 || bus.c_result_id_o !== prev_id || bus.c_result_data_o !== prev_d) begin errors++; $display("[TB] FAIL rr_stream[%0d]: got v=%b id=%0d want v=1 id=%0d", i, bus.c_result_valid_o, bus.c_result_id_o, prev_id); end
            end
            prev_id = (i % 2 == 0) ? 4'd10 : 4'd11;
            prev_d = (i % 2 == 0) ? d0 : d1;
            tick();
        end
    endtask

    task automatic test_kill();
        apply_reset();
        do_issue(5, 2'b01);
        clear_inputs();
        #1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL kill_busy_before: got %b want 1", busy_o); end
        bus.c_commit_valid_i = 1'b1; bus.c_commit_id_i = 4'd5; bus.c_commit_kill_i = 1'b1;
        #1;
        checks++; if (bus.cp_commit_valid_o !== 2'b01 || bus.cp_commit_kill_o !== 1'b1) begin errors++; $display("[TB] FAIL kill_commit: got v=%b k=%b want 01 1", bus.cp_commit_valid_o, bus.cp_commit_kill_o); end
        tick();
        clear_inputs();
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy_after: got %b want 0", busy_o); end
        for (int i = 0; i < 3; i++) do_issue(5 + i, 2'b01);
        clear_inputs();
        bus.c_issue_valid_i = 1'b1; bus.c_issue_id_i = 4'd8;
        bus.cp_issue_ready_i = 2'b11; bus.cp_issue_accept_i = 2'b01;
        #1;
        checks++; if (bus.cp_issue_valid_o[0] !== 1'b1) begin errors++; $display("[TB] FAIL kill_count: got %b want 1", bus.cp_issue_valid_o[0]); end
        checks++; if (bus.c_result_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL kill_no_result: got %b want 0", bus.c_result_valid_o); end
        tick();
    endtask

    task automatic test_reissue();
        apply_reset();
        do_issue(2, 2'b10);
        clear_inputs();
        bus.c_issue_valid_i = 1'b1; bus.c_issue_id_i = 4'd2;
        bus.cp_issue_ready_i = 2'b11; bus.cp_issue_accept_i = 2'b11;
        #1;
        checks++; if (bus.c_issue_ready_o !== 1'b0 || bus.cp_issue_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL reissue_stall: got r=%b v=%b want 0 00", bus.c_issue_ready_o, bus.cp_issue_valid_o); end
        tick();
        bus.cp_result_valid_i = 2'b10;
        bus.cp_result_id_i[ID_W +: ID_W] = 4'd2;
        bus.c_result_ready_i = 1'b1;
        #1;
        checks++; if (bus.c_issue_ready_o !== 1'b0 || bus.cp_result_ready_o !== 2'b10) begin errors++; $display("[TB] FAIL reissue_same_cycle: got r=%b g=%b want 0 10", bus.c_issue_ready_o, bus.cp_result_ready_o); end
        tick();
        bus.cp_result_valid_i = 2'b00;
        #1;
        checks++; if (bus.c_issue_ready_o !== 1'b1 || bus.c_issue_accept_o !== 1'b1) begin errors++; $display("[TB] FAIL reissue_release: got r=%b a=%b want 1 1", bus.c_issue_ready_o, bus.c_issue_accept_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_issue(1, 2'b01);
        do_issue(2, 2'b10);
        do_issue(3, 2'b01);
        clear_inputs();
        bus.cp_result_valid_i = 2'b01;
        bus.cp_result_id_i[0 +: ID_W] = 4'd1;
        tick();
        clear_inputs();
        #1;
        checks++; if (bus.c_result_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pending: got %b want 1", bus.c_result_valid_o); end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        checks++; if (bus.c_result_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_clear: got v=%b busy=%b want 0 0", bus.c_result_valid_o, busy_o); end
        bus.c_commit_valid_i = 1'b1; bus.c_commit_id_i = 4'd2;
        #1;
        checks++; if (bus.cp_commit_valid_o !== 2'b00) begin errors++; $display("[TB] FAIL midrst_commit: got %b want 00", bus.cp_commit_valid_o); end
        tick();
    endtask

    task automatic test_random();
        int r, pick;
        bit exp_busy;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            rst_i = ($urandom_range(0, 99) == 0);
            bus.c_issue_valid_i   = 1'($urandom_range(0, 1));
            bus.c_issue_id_i      = ID_W'($urandom_range(0, DEPTH - 1));
            bus.c_issue_payload_i = {$urandom, $urandom, $urandom};
            bus.cp_issue_ready_i  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            bus.cp_issue_accept_i = 2'($urandom_range(0, 3));
            bus.c_commit_valid_i  = ($urandom_range(0, 3) == 0);
            bus.c_commit_id_i     = ID_W'($urandom_range(0, DEPTH - 1));
            bus.c_commit_kill_i   = 1'($urandom_range(0, 1));
            bus.c_result_ready_i  = 1'($urandom_range(0, 1));
            for (int k = 0; k < NUM_CP; k++) begin
                bus.cp_result_valid_i[k] = ($urandom_range(0, 2) == 0);
                r = $urandom_range(0, DEPTH - 1);
                pick = r;
                if ($urandom_range(0, 3) != 0) begin
                    for (int j = DEPTH - 1; j >= 0; j--) begin
                        if (m_valid[(r + j) % DEPTH] && m_owner[(r + j) % DEPTH] == k) pick = (r + j) % DEPTH;
                    end
                end
                bus.cp_result_id_i[k*ID_W +: ID_W] = ID_W'(pick);
                bus.cp_result_data_i[k*RES_W +: RES_W] = RES_W'({$urandom, $urandom});
            end
            #1;
            model_eval();
            exp_busy = m_full;
            for (int i = 0; i < DEPTH; i++) if (m_valid[i]) exp_busy = 1'b1;
            checks++; if (bus.cp_issue_valid_o !== e_cp_issue_valid) begin errors++; $display("[TB] FAIL rnd_offer@%0d: got %b want %b", n, bus.cp_issue_valid_o, e_cp_issue_valid); end
            checks++; if (bus.c_issue_ready_o !== e_issue_ready) begin errors++; $display("[TB] FAIL rnd_ready@%0d: got %b want %b", n, bus.c_issue_ready_o, e_issue_ready); end
            checks++; if (bus.c_issue_accept_o !== e_issue_accept) begin errors++; $display("[TB] FAIL rnd_accept@%0d: got %b want %b", n, bus.c_issue_accept_o, e_issue_accept); end
            checks++; if (bus.cp_commit_valid_o !== e_commit_valid) begin errors++; $display("[TB] FAIL rnd_commit@%0d: got %b want %b", n, bus.cp_commit_valid_o, e_commit_valid); end
            checks++; if (bus.cp_result_ready_o !== e_res_ready) begin errors++; $display("[TB] FAIL rnd_grant@%0d: got %b want %b", n, bus.cp_result_ready_o, e_res_ready); end
            checks++; if (bus.c_result_valid_o !== m_full) begin errors++; $display("[TB] FAIL rnd_res_valid@%0d: got %b want %b", n, bus.c_result_valid_o, m_full); end
            checks++; if (busy_o !== exp_busy) begin errors++; $display("[TB] FAIL rnd_busy@%0d: got %b want %b", n, busy_o, exp_busy); end
            if (m_full) begin
                checks++; if (bus.c_result_id_o !== m_res_id || bus.c_result_data_o !== m_res_data) begin errors++; $display("[TB] FAIL rnd_res_payload@%0d: got id=%0d want id=%0d", n, bus.c_result_id_o, m_res_id); end
            end
            tick();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_owner[i] = 0; end
        for (int k = 0; k < NUM_CP; k++) m_outst[k] = 0;
        test_reset();
        test_issue_route();
        test_max_outst();
        test_round_robin();
        test_kill();
        test_reissue();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
